// File: rtl/core6502_pkg.sv
// Shared definitions for the Core6502 timing generator: T-state one-hot
// positions, debug encodings and the forced interrupt opcode.
package core6502_pkg;

    localparam int T0_IDX = 0;
    localparam int T1_IDX = 1;
    localparam int T2_IDX = 2;
    localparam int T3_IDX = 3;
    localparam int T4_IDX = 4;
    localparam int T5_IDX = 5;

    localparam logic [2:0] T0_ENC = 3'd0;
    localparam logic [2:0] T1_ENC = 3'd1;
    localparam logic [2:0] T2_ENC = 3'd2;
    localparam logic [2:0] T3_ENC = 3'd3;
    localparam logic [2:0] T4_ENC = 3'd4;
    localparam logic [2:0] T5_ENC = 3'd5;

    localparam logic [7:0] BRK_OPCODE = 8'h00;

    typedef enum logic [5:0] {
        ST_T0 = 6'b000001,
        ST_T1 = 6'b000010,
        ST_T2 = 6'b000100,
        ST_T3 = 6'b001000,
        ST_T4 = 6'b010000,
        ST_T5 = 6'b100000
    } t_state_e;

endpackage

// File: rtl/t_sequencer_ir_latch.sv
// Instruction register: captures the opcode on the T1->T2 edge, substituting
// the forced BRK opcode when an interrupt is pending, and flags that injection.
module ir_latch
    import core6502_pkg::*;
#(
    parameter logic [7:0] IR_RESET = BRK_OPCODE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       load,
    input  logic       int_pend,
    input  logic [7:0] db,
    output logic [7:0] ir,
    output logic [7:0] n_ir,
    output logic       ir01,
    output logic       int_taken
);

    logic [7:0] ir_reg;
    logic       int_taken_reg;

    // int_taken only updates on advancing cycles, so a stall stretches the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg        <= IR_RESET;
            int_taken_reg <= 1'b0;
        end else if (rdy) begin
            int_taken_reg <= load & int_pend;
            if (load) begin
                ir_reg <= int_pend ? IR_RESET : db;
            end
        end
    end

    assign ir        = ir_reg;
    assign n_ir      = ~ir_reg;
    assign ir01      = ir_reg[0] | ir_reg[1];
    assign int_taken = int_taken_reg;

endmodule

// File: rtl/t_sequencer.sv
// T-state timing generator for the Core6502 decoder: one-hot T0..T5 machine,
// active-low strobes, SYNC, overrun detection and the instruction register.
module t_sequencer
    import core6502_pkg::*;
#(
    parameter logic [7:0] IR_RESET = BRK_OPCODE,
    parameter int          T_MAX    = 5
) (
    input  logic       PHI0,
    input  logic       n_RES,
    input  logic       RDY,
    input  logic [7:0] DB,
    input  logic       END_REQ,
    input  logic       INT_PEND,
    output logic       n_T0,
    output logic       n_T1X,
    output logic       n_T2,
    output logic       n_T3,
    output logic       n_T4,
    output logic       n_T5,
    output logic       SYNC,
    output logic [7:0] IR,
    output logic [7:0] n_IR,
    output logic       IR01,
    output logic       INT_TAKEN,
    output logic       SEQ_ERR,
    output logic [2:0] T_STATE
);

    t_state_e state_reg;
    logic     seq_err_reg;
    logic     at_max;

    assign at_max = state_reg[T_MAX];

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            state_reg   <= ST_T2;
            seq_err_reg <= 1'b0;
        end else if (RDY) begin
            case (state_reg)
                ST_T0: state_reg <= ST_T1;
                ST_T1: state_reg <= ST_T2;
                default: begin
                    // Execute states: the last cycle is either requested or forced at T_MAX
                    if (END_REQ || at_max) begin
                        state_reg <= ST_T0;
                        if (!END_REQ) begin
                            seq_err_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= t_state_e'({state_reg[4:0], 1'b0});
                    end
                end
            endcase
        end
    end

    ir_latch #(
        .IR_RESET(IR_RESET)
    ) u_ir_latch (
        .clk      (PHI0),
        .rst_n    (n_RES),
        .rdy      (RDY),
        .load     (state_reg[T1_IDX]),
        .int_pend (INT_PEND),
        .db       (DB),
        .ir       (IR),
        .n_ir     (n_IR),
        .ir01     (IR01),
        .int_taken(INT_TAKEN)
    );

    assign n_T0    = ~state_reg[T0_IDX];
    assign n_T1X   = ~state_reg[T1_IDX];
    assign n_T2    = ~state_reg[T2_IDX];
    assign n_T3    = ~state_reg[T3_IDX];
    assign n_T4    = ~state_reg[T4_IDX];
    assign n_T5    = ~state_reg[T5_IDX];
    assign SYNC    = state_reg[T1_IDX];
    assign SEQ_ERR = seq_err_reg;

    always_comb begin
        T_STATE = T0_ENC;
        case (state_reg)
            ST_T0:   T_STATE = T0_ENC;
            ST_T1:   T_STATE = T1_ENC;
            ST_T2:   T_STATE = T2_ENC;
            ST_T3:   T_STATE = T3_ENC;
            ST_T4:   T_STATE = T4_ENC;
            ST_T5:   T_STATE = T5_ENC;
            default: T_STATE = T0_ENC;
        endcase
    end

endmodule

// File: tb/tb_t_sequencer.sv
// Self-checking bench for t_sequencer: directed vector table, async reset
// sequence and randomized run against a cycle-count reference model.
module tb_t_sequencer;

    localparam int         T_MAX    = 5;
    localparam logic [7:0] IR_RESET = 8'h00;

    logic       PHI0 = 1'b0;
    logic       n_RES;
    logic       RDY;
    logic [7:0] DB;
    logic       END_REQ;
    logic       INT_PEND;
    logic       n_T0, n_T1X, n_T2, n_T3, n_T4, n_T5;
    logic       SYNC;
    logic [7:0] IR;
    logic [7:0] n_IR;
    logic       IR01;
    logic       INT_TAKEN;
    logic       SEQ_ERR;
    logic [2:0] T_STATE;

    int tests  = 0;
    int failed = 0;

    // Reference model: position in the instruction as a plain integer
    int         m_t;
    logic [7:0] m_ir;
    logic       m_itk;
    logic       m_err;

    typedef struct {
        logic       rdy;
        logic [7:0] db;
        logic       end_req;
        logic       int_pend;
        int         exp_t;
        logic [7:0] exp_ir;
        logic       exp_itk;
        logic       exp_err;
    } vec_t;

    vec_t vecs[21];

    t_sequencer #(
        .IR_RESET(IR_RESET),
        .T_MAX   (T_MAX)
    ) dut (
        .PHI0     (PHI0),
        .n_RES    (n_RES),
        .RDY      (RDY),
        .DB       (DB),
        .END_REQ  (END_REQ),
        .INT_PEND (INT_PEND),
        .n_T0     (n_T0),
        .n_T1X    (n_T1X),
        .n_T2     (n_T2),
        .n_T3     (n_T3),
        .n_T4     (n_T4),
        .n_T5     (n_T5),
        .SYNC     (SYNC),
        .IR       (IR),
        .n_IR     (n_IR),
        .IR01     (IR01),
        .INT_TAKEN(INT_TAKEN),
        .SEQ_ERR  (SEQ_ERR),
        .T_STATE  (T_STATE)
    );

    always #5 PHI0 = ~PHI0;

    task automatic check(input string name, input int t, input logic [7:0] ir,
                         input logic itk, input logic err);
        logic [5:0] strobes;
        logic [5:0] exp_strobes;
        logic       ok;
        strobes     = {n_T5, n_T4, n_T3, n_T2, n_T1X, n_T0};
        exp_strobes = ~(6'b000001 << t);
        ok = (strobes == exp_strobes) && (int'(T_STATE) == t) && (SYNC == (t == 1)) &&
             (IR == ir) && (n_IR == ~ir) && (IR01 == (ir[0] | ir[1])) &&
             (INT_TAKEN == itk) && (SEQ_ERR == err);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s: got strobes=%b T=%0d sync=%b ir=%h nir=%h ir01=%b itk=%b err=%b, want strobes=%b T=%0d ir=%h itk=%b err=%b",
                     name, strobes, T_STATE, SYNC, IR, n_IR, IR01, INT_TAKEN, SEQ_ERR,
                     exp_strobes, t, ir, itk, err);
        end else begin
            $display("[TB] %s ok: T%0d ir=%h itk=%b err=%b", name, t, ir, itk, err);
        end
    endtask

    task automatic drive(input logic rdy, input logic [7:0] db, input logic end_req,
                         input logic int_pend);
        RDY      = rdy;
        DB       = db;
        END_REQ  = end_req;
        INT_PEND = int_pend;
    endtask

    // Advances the model by one clock edge from the spec rules
    task automatic model_edge();
        int nt;
        if (RDY) begin
            m_itk = 1'b0;
            if (m_t == 0) begin
                nt = 1;
            end else if (m_t == 1) begin
                m_ir  = INT_PEND ? IR_RESET : DB;
                m_itk = INT_PEND;
                nt    = 2;
            end else if (m_t == T_MAX) begin
                if (!END_REQ) m_err = 1'b1;
                nt = 0;
            end else begin
                nt = END_REQ ? 0 : m_t + 1;
            end
            m_t = nt;
        end
    endtask

    task automatic model_reset();
        m_t   = 2;
        m_ir  = IR_RESET;
        m_itk = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        n_RES = 1'b0;
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge PHI0);
        #1;
        model_reset();
        check("reset", 2, IR_RESET, 1'b0, 1'b0);
        @(negedge PHI0);
        n_RES = 1'b1;
    endtask

    initial begin
        //          rdy   db     end   ip    t  ir     itk   err
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hA9, 1'b0, 1'b0, 2, 8'hA9, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 8'hA9, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 8'hA9, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'hEA, 1'b0, 1'b1, 2, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 3, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 3, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 3, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 4, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 8'h4C, 1'b0, 1'b0, 2, 8'h4C, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 8'h4C, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 8'h4C, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 8'h02, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 3, 8'h02, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 8'h00, 1'b0, 1'b0, 4, 8'h02, 1'b0, 1'b1};

        do_reset();

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rdy, vecs[i].db, vecs[i].end_req, vecs[i].int_pend);
            @(posedge PHI0);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_ir,
                  vecs[i].exp_itk, vecs[i].exp_err);
        end

        // Interrupt pulse stretched by a stall: T1 with INT_PEND, then RDY low in T2
        do_reset();
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge PHI0);
        drive(1'b1, 8'h6C, 1'b0, 1'b1);
        @(posedge PHI0);
        #1;
        check("int_inject", 2, IR_RESET, 1'b1, 1'b0);
        drive(1'b0, 8'h6C, 1'b1, 1'b0);
        repeat (2) @(posedge PHI0);
        #1;
        check("int_stall", 2, IR_RESET, 1'b1, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        @(posedge PHI0);
        #1;
        check("int_release", 3, IR_RESET, 1'b0, 1'b0);

        // Async reset in mid-instruction while SEQ_ERR is set, between clock edges
        do_reset();
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (4) @(posedge PHI0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        @(posedge PHI0);
        repeat (3) @(posedge PHI0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        #1;
        check("pre_async", 4, 8'h33, 1'b0, 1'b1);
        #2;
        n_RES = 1'b0;
        #1;
        check("async_reset", 2, IR_RESET, 1'b0, 1'b0);
        @(negedge PHI0);
        n_RES = 1'b1;
        model_reset();

        // Randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0,
                  ($urandom % 4) == 0);
            @(posedge PHI0);
            model_edge();
            #1;
            check($sformatf("rnd%0d", i), m_t, m_ir, m_itk, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/t_sequencer.md
Name: t_sequencer

Overview:
- Instruction-cycle timing generator and instruction-register owner for the Core6502 random-logic decoder.
- Produces the active-low T-state strobes (n_T0, n_T1X, n_T2..n_T5), latches the opcode into IR/n_IR/IR01, and injects the forced-BRK opcode for interrupts.
- Honours the RDY stall and accepts end-of-instruction requests from the decoder/random logic, closing the loop around the decoder PLA.

Parameters:
- IR_RESET, 8'h00, IR value loaded on reset; also the opcode forced on interrupt entry (BRK).
- T_MAX, 5, last T-state reachable without an end request; must be in 2..5.

Ports:
- PHI0  in  1  single core clock; all state changes on the rising edge.
- n_RES  in  1  asynchronous active-low reset.
- RDY  in  1  1 = advance; 0 = freeze all state, IR and outputs.
- DB  in  8  data bus; carries the opcode during T1.
- END_REQ  in  1  from decoder/random logic; sampled in T2..T5; 1 = this is the last execute cycle.
- INT_PEND  in  1  pending IRQ/NMI; sampled at the T1 edge.
- n_T0  out  1  low during T0 (final cycle).
- n_T1X  out  1  low during T1 (opcode fetch).
- n_T2, n_T3, n_T4, n_T5  out  1 each  low during the matching state.
- SYNC  out  1  high during T1.
- IR  out  8  instruction register.
- n_IR  out  8  bitwise complement of IR.
- IR01  out  1  IR[0] | IR[1].
- INT_TAKEN  out  1  one-cycle pulse in the T2 that follows an injected BRK.
- SEQ_ERR  out  1  sticky; set when T_MAX is reached with no END_REQ.
- T_STATE  out  3  debug encoding: T0=0 .. T5=5.

Behaviour:
- State is one-hot over {T0,T1,T2,T3,T4,T5}; exactly one n_T* output is low at any time.
- Reset (n_RES low, asynchronous): state=T2, IR=IR_RESET, SYNC=0, INT_TAKEN=0, SEQ_ERR=0, n_T2=0, all other n_T*=1. The first cycles after release therefore execute the BRK/reset sequence.
- All transitions are gated by RDY=1. With RDY=0, state, IR, SEQ_ERR and every output hold. INT_TAKEN also holds, so a pulse stretches across the stall.
- T1 -> T2: IR <= INT_PEND ? IR_RESET : DB. INT_TAKEN=1 during the following T2 iff INT_PEND was sampled 1.
- Tn (n=2..T_MAX-1): END_REQ=1 -> T0; otherwise -> Tn+1.
- T_MAX: -> T0 unconditionally. If END_REQ=0, SEQ_ERR <= 1.
- T0 -> T1.
- Minimum instruction length is 3 cycles (T1,T2,T0). END_REQ is ignored in T0 and T1.
- IR changes only on the T1->T2 edge. n_IR and IR01 are combinational from IR, with no added latency.
- END_REQ and INT_PEND are sampled only when RDY=1.
- n_RES asserted in mid-instruction aborts it immediately to the reset values. SEQ_ERR clears only on reset.
- T_STATE is combinational from the one-hot state.

Decomposition:
- Shared package core6502_pkg holds:
  - T-state index constants T0_IDX..T5_IDX (one-hot bit positions) and the 3-bit debug encodings;
  - BRK_OPCODE = 8'h00.
- Natural sub-module: ir_latch, covering IR register, interrupt mux, n_IR/IR01 generation and RDY gating.
- The state machine stays in t_sequencer.

Test Plan:
- Reset release with RDY=1, END_REQ asserted in T3 -> strobes T2,T3,T0,T1,T2. IR=8'h00 until the T1 edge. SEQ_ERR=0.
- Fetch opcode: DB=8'hA9 in T1, INT_PEND=0 -> IR=8'hA9, n_IR=8'h56, IR01=1 from T2. With END_REQ=1 in T2, the sequence is T2,T0,T1.
- Interrupt injection: DB=8'hEA in T1, INT_PEND=1 -> IR=8'h00, IR01=0, INT_TAKEN=1 for exactly one T2 cycle.
- Stall: RDY=0 for 3 cycles while in T3 -> n_T3 stays low for 4 cycles total; IR unchanged; then normal advance.
- Overrun: END_REQ=0 through T5 -> next state T0, SEQ_ERR=1 and remains 1 across the following instructions until n_RES.
- Async reset pulse in T4 between clock edges -> outputs go immediately to n_T2=0, IR=8'h00, SEQ_ERR=0 without waiting for PHI0.
